// File: rtl/arm_servo_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arm_servo_test_pkg
//  Purpose  : Shared types, timing constants and width helpers for the
//             robotic-arm servo exerciser.
//  Revision : 1.0  initial release
// ============================================================================
package arm_servo_test_pkg;

    // PWM frame geometry
    localparam int PERIOD_CYC  = 500;
    localparam int WIDTH_BITS  = $clog2(PERIOD_CYC + 1);
    localparam int CNT_BITS    = $clog2(PERIOD_CYC);

    typedef logic [WIDTH_BITS-1:0] width_t;
    typedef logic [CNT_BITS-1:0]   cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(PERIOD_CYC - 1);

    // Default pulse widths, in clk cycles
    localparam width_t MIN_W         = width_t'(25);
    localparam width_t MAX_W         = width_t'(75);
    localparam width_t STEP_W        = width_t'(5);
    localparam width_t CATCH_OPEN_W  = width_t'(25);
    localparam width_t CATCH_CLOSE_W = width_t'(60);

    // Frames spent in each hold state
    localparam int HOLD_FRAMES = 2;
    localparam int HOLD_BITS   = $clog2(HOLD_FRAMES + 1);
    typedef logic [HOLD_BITS-1:0] hold_t;
    localparam hold_t HOLD_LAST = hold_t'(HOLD_FRAMES - 1);

    // Sequencer states
    typedef enum logic [2:0] {
        ST_HOME    = 3'd0,
        ST_REACH   = 3'd1,
        ST_GRAB    = 3'd2,
        ST_LIFT    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RETURN  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Add step to w, clamping at lim; computed one bit wider to avoid wrap
    function automatic width_t sat_add(input width_t w, input width_t step, input width_t lim);
        logic [WIDTH_BITS:0] sum;
        sum = {1'b0, w} + {1'b0, step};
        return (sum >= {1'b0, lim}) ? lim : sum[WIDTH_BITS-1:0];
    endfunction

    // Subtract step from w, clamping at lim
    function automatic width_t sat_sub(input width_t w, input width_t step, input width_t lim);
        logic [WIDTH_BITS:0] floor_sum;
        floor_sum = {1'b0, lim} + {1'b0, step};
        return ({1'b0, w} >= floor_sum) ? (w - step) : lim;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_servo_test_if.sv
`default_nettype none
// ============================================================================
//  Module   : arm_servo_test_if
//  Purpose  : Bundle of the three servo PWM lines (shoulder, elbow, gripper).
//  Revision : 1.0  initial release
// ============================================================================
interface arm_servo_test_if;

    logic pwm1;       // shoulder
    logic pwm2;       // elbow
    logic catch_pwm;  // gripper

    modport master (output pwm1, output pwm2, output catch_pwm);
    modport slave  (input  pwm1, input  pwm2, input  catch_pwm);

endinterface
`default_nettype wire

// File: rtl/arm_servo_test_servo_pwm_ch.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_ch
//  Purpose  : One servo PWM channel. Holds a shadow copy of the pulse width
//             that only reloads at the frame boundary so a pulse is never
//             cut or stretched mid-frame; output is a registered compare.
//  Revision : 1.0  initial release
// ============================================================================
module servo_pwm_ch
    import arm_servo_test_pkg::*;
#(
    parameter width_t RESET_W = MIN_W
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire cnt_t   cnt,
    input  wire logic   frame_boundary,
    input  wire width_t target,
    output logic        pwm
);

    width_t active;

    // Shadow-width reload at frame boundary and registered compare output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= RESET_W;
            pwm    <= 1'b0;
        end else begin
            if (frame_boundary) begin
                active <= target;
            end
            pwm <= (width_t'(cnt) < active);
        end
    end

endmodule
`default_nettype wire

// File: rtl/arm_servo_test.sv
`default_nettype none
// ============================================================================
//  Module   : arm_servo_test
//  Purpose  : Self-running robotic-arm exerciser. Shared PWM frame counter
//             plus a sequencer that walks reach/grab/lift/release/return,
//             driving shoulder, elbow and gripper servo channels.
//  Config   : ARM_TEST_LOOP_EN - defined: sequence repeats forever;
//             undefined: park in DONE emitting home-width frames.
//  Revision : 1.0  initial release
// ============================================================================
module arm_servo_test
    import arm_servo_test_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    arm_servo_test_if.master   servo
);

    cnt_t   cnt;
    logic   frame_boundary;

    state_t state, state_nxt;
    hold_t  hold_cnt, hold_nxt;
    width_t w1, w2, wc;
    width_t w1_nxt, w2_nxt, wc_nxt;

    logic   pwm1_out, pwm2_out, catch_out;

    assign frame_boundary = (cnt == CNT_LAST);

    // Free-running frame counter, 0..PERIOD_CYC-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (frame_boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sequencer state, hold counter and target widths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_HOME;
            hold_cnt <= '0;
            w1       <= MIN_W;
            w2       <= MIN_W;
            wc       <= CATCH_OPEN_W;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            w1       <= w1_nxt;
            w2       <= w2_nxt;
            wc       <= wc_nxt;
        end
    end

    // Next-state and target-width decisions, taken only at frame boundaries
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        w1_nxt    = w1;
        w2_nxt    = w2;
        wc_nxt    = wc;
        if (frame_boundary) begin
            case (state)
                ST_HOME: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_REACH;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + 1'b1;
                    end
                end
                ST_REACH: begin
                    if (w1 == MAX_W) begin
                        state_nxt = ST_GRAB;
                        hold_nxt  = '0;
                    end else begin
                        w1_nxt    = sat_add(w1, STEP_W, MAX_W);
                    end
                end
                ST_GRAB: begin
                    wc_nxt = CATCH_CLOSE_W;
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_LIFT;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + 1'b1;
                    end
                end
                ST_LIFT: begin
                    if (w2 == MAX_W) begin
                        state_nxt = ST_RELEASE;
                        hold_nxt  = '0;
                    end else begin
                        w2_nxt    = sat_add(w2, STEP_W, MAX_W);
                    end
                end
                ST_RELEASE: begin
                    wc_nxt = CATCH_OPEN_W;
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_RETURN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + 1'b1;
                    end
                end
                ST_RETURN: begin
                    if ((w1 == MIN_W) && (w2 == MIN_W)) begin
`ifdef ARM_TEST_LOOP_EN
                        state_nxt = ST_HOME;
`else
                        state_nxt = ST_DONE;
`endif
                        hold_nxt  = '0;
                    end else begin
                        w1_nxt    = sat_sub(w1, STEP_W, MIN_W);
                        w2_nxt    = sat_sub(w2, STEP_W, MIN_W);
                    end
                end
                ST_DONE: begin
                    // Terminal: keep emitting home-width frames until reset
                    w1_nxt = MIN_W;
                    w2_nxt = MIN_W;
                    wc_nxt = CATCH_OPEN_W;
                end
                default: begin
                    state_nxt = ST_HOME;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // Next-target values feed the channels so a boundary update lands in the
    // very next frame
    servo_pwm_ch #(.RESET_W(MIN_W)) u_shoulder (
        .clk            (clk),
        .rst_n          (rst_n),
        .cnt            (cnt),
        .frame_boundary (frame_boundary),
        .target         (w1_nxt),
        .pwm            (pwm1_out)
    );

    servo_pwm_ch #(.RESET_W(MIN_W)) u_elbow (
        .clk            (clk),
        .rst_n          (rst_n),
        .cnt            (cnt),
        .frame_boundary (frame_boundary),
        .target         (w2_nxt),
        .pwm            (pwm2_out)
    );

    servo_pwm_ch #(.RESET_W(CATCH_OPEN_W)) u_gripper (
        .clk            (clk),
        .rst_n          (rst_n),
        .cnt            (cnt),
        .frame_boundary (frame_boundary),
        .target         (wc_nxt),
        .pwm            (catch_out)
    );

    assign servo.pwm1      = pwm1_out;
    assign servo.pwm2      = pwm2_out;
    assign servo.catch_pwm = catch_out;

endmodule
`default_nettype wire

// File: tb/tb_arm_servo_test.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arm_servo_test
//  Purpose  : Self-checking bench for arm_servo_test. A frame-level timeline
//             of expected widths is built from the sequence rules and every
//             output sample of every frame is compared against it.
//  Config   : honours ARM_TEST_LOOP_EN the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arm_servo_test;

    localparam int T_PERIOD = 500;
    localparam int T_MIN    = 25;
    localparam int T_MAX    = 75;
    localparam int T_STEP   = 5;
    localparam int T_OPEN   = 25;
    localparam int T_CLOSE  = 60;
    localparam int T_HOLD   = 2;
    localparam int N_FRAMES = 45;

    logic clk;
    logic rst_n;

    arm_servo_test_if servo_bus ();

    arm_servo_test dut (
        .clk   (clk),
        .rst_n (rst_n),
        .servo (servo_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_w1[$];
    int exp_w2[$];
    int exp_wc[$];

    // Single comparison point for the whole bench
    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int a, input int b, input int c);
        exp_w1.push_back(a);
        exp_w2.push_back(b);
        exp_wc.push_back(c);
    endtask

    // Frame-by-frame timeline: each state shows its current widths for a
    // frame, then applies its change at the end of that frame
    task automatic build_model(input int nframes);
        int a1, a2, ac;
        a1 = T_MIN; a2 = T_MIN; ac = T_OPEN;
        while (exp_w1.size() < nframes) begin
            repeat (T_HOLD) push_frame(a1, a2, ac);                 // HOME
            push_frame(a1, a2, ac);                                 // REACH
            while (a1 != T_MAX) begin
                a1 = (a1 + T_STEP > T_MAX) ? T_MAX : a1 + T_STEP;
                push_frame(a1, a2, ac);
            end
            for (int i = 0; i < T_HOLD; i++) begin                  // GRAB
                push_frame(a1, a2, ac);
                ac = T_CLOSE;
            end
            push_frame(a1, a2, ac);                                 // LIFT
            while (a2 != T_MAX) begin
                a2 = (a2 + T_STEP > T_MAX) ? T_MAX : a2 + T_STEP;
                push_frame(a1, a2, ac);
            end
            for (int i = 0; i < T_HOLD; i++) begin                  // RELEASE
                push_frame(a1, a2, ac);
                ac = T_OPEN;
            end
            push_frame(a1, a2, ac);                                 // RETURN
            while (!(a1 == T_MIN && a2 == T_MIN)) begin
                a1 = (a1 - T_STEP < T_MIN) ? T_MIN : a1 - T_STEP;
                a2 = (a2 - T_STEP < T_MIN) ? T_MIN : a2 - T_STEP;
                push_frame(a1, a2, ac);
            end
`ifndef ARM_TEST_LOOP_EN
            while (exp_w1.size() < nframes) push_frame(T_MIN, T_MIN, T_OPEN);
`endif
        end
    endtask

    // Sample every cycle of `count` frames starting right after reset release;
    // each channel must be high for exactly the first w samples of the frame
    task automatic check_frames(input int count);
        int   hi [3];
        int   bad[3];
        int   wexp[3];
        logic s[3];
        string nm[3];
        nm[0] = "pwm1"; nm[1] = "pwm2"; nm[2] = "catch_pwm";
        for (int f = 0; f < count; f++) begin
            wexp[0] = exp_w1[f]; wexp[1] = exp_w2[f]; wexp[2] = exp_wc[f];
            for (int c = 0; c < 3; c++) begin hi[c] = 0; bad[c] = 0; end
            for (int p = 0; p < T_PERIOD; p++) begin
                @(negedge clk);
                s[0] = servo_bus.pwm1; s[1] = servo_bus.pwm2; s[2] = servo_bus.catch_pwm;
                for (int c = 0; c < 3; c++) begin
                    if (s[c] === 1'b1) hi[c]++;
                    if (s[c] !== ((p < wexp[c]) ? 1'b1 : 1'b0)) bad[c]++;
                end
            end
            for (int c = 0; c < 3; c++) begin
                check_val($sformatf("frame%0d %s width", f, nm[c]), hi[c], wexp[c]);
                check_val($sformatf("frame%0d %s misplaced samples", f, nm[c]), bad[c], 0);
            end
        end
    endtask

    task automatic check_outputs_low(input string tag);
        check_val({tag, " pwm1"},      int'(servo_bus.pwm1),      0);
        check_val({tag, " pwm2"},      int'(servo_bus.pwm2),      0);
        check_val({tag, " catch_pwm"}, int'(servo_bus.catch_pwm), 0);
    endtask

    initial begin
        int abort_frame;
        int abort_pos;
        int rst_len;

        build_model(N_FRAMES);

        // LIFT spans frames 15..25 of the first pass
        abort_frame = $urandom_range(25, 15);
        abort_pos   = $urandom_range(60, 5);
        rst_len     = $urandom_range(20, 3);

        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_outputs_low("power-on reset");
        rst_n = 1'b1;

        // First pass up to a random point inside LIFT
        check_frames(abort_frame);
        for (int p = 0; p < abort_pos; p++) @(negedge clk);
        check_val("pre-reset pwm1", int'(servo_bus.pwm1),
                  ((abort_pos - 1) < exp_w1[abort_frame]) ? 1 : 0);

        // Asynchronous reset between clock edges must clear outputs at once
        #2 rst_n = 1'b0;
        #1 check_outputs_low("async reset");
        repeat (rst_len) @(negedge clk);
        check_outputs_low("held reset");
        rst_n = 1'b1;

        // Full pass from HOME, then what follows completion
        check_frames(43);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
